// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, FSM state enum and request record for the ALU issue controller
//
// Contents:
//   DATA_W       operand / result width
//   OP_W         ALU control code width
//   alu_state_t  issue FSM states (IDLE, DRIVE, HOLD)
//   alu_req_t    one buffered request {a, b, op}
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } alu_req_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - request, ALU and result signal bundle of the ALU issue controller
//
// Signals:
//   req_valid/req_ready/req_a/req_b/req_op  upstream request handshake
//   alu_a/alu_b/alu_ctrl/alu_out            connection to the external combinational ALU
//   res_valid/res_ready/res_data/res_op     downstream result handshake
//   busy                                    controller activity flag
// Modports:
//   slave   the controller side
//   master  the environment side (request source, ALU, result sink)
interface alu_issue_ctrl_if;
    import alu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [OP_W-1:0]   req_op;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_ctrl;
    logic [DATA_W-1:0] alu_out;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [OP_W-1:0]   res_op;

    logic              busy;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_out, res_ready,
        output req_ready, alu_a, alu_b, alu_ctrl, res_valid, res_data, res_op, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_out, res_ready,
        input  req_ready, alu_a, alu_b, alu_ctrl, res_valid, res_data, res_op, busy
    );

endinterface

// File: rtl/alu_req_fifo.sv
// rtl/alu_req_fifo.sv - small in-order request buffer ahead of the ALU
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset, empties the buffer
//   i_push       write i_push_data this cycle (caller guarantees not full)
//   i_push_data  request record to store
//   i_pop        drop the head entry this cycle (caller guarantees not empty)
//   o_pop_data   current head entry
//   o_full       all DEPTH entries occupied
//   o_empty      no entries occupied
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_push,
    input  alu_req_t i_push_data,
    input  logic     i_pop,
    output alu_req_t o_pop_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    alu_req_t       r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_full     = (r_count == FULL_CNT);
    assign o_empty    = (r_count == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - buffers ALU requests, drives them to an external combinational ALU and captures results
//
// Parameters:
//   SETTLE_CYCLES  cycles the ALU inputs are held before the result is sampled (1..7)
//   FIFO_DEPTH     request buffer depth (2)
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset; discards in-flight and buffered work
//   bus    alu_issue_ctrl_if.slave: request handshake, ALU drive/return, result handshake, busy
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_ctrl_if.slave bus
);

    localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES);

    alu_state_t        r_state;
    logic [2:0]        r_cnt;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OP_W-1:0]   r_op;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic [OP_W-1:0]   r_res_op;

    alu_req_t          w_push_data;
    alu_req_t          w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_res_fire;

    assign w_push_data = '{a: bus.req_a, b: bus.req_b, op: bus.req_op};
    assign w_push      = bus.req_valid && !w_full;
    assign w_res_fire  = r_res_valid && bus.res_ready;

    // The head leaves the buffer either from IDLE or on the same edge the
    // current result is taken, so back-to-back results skip IDLE entirely.
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && w_res_fire));

    alu_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_op    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_a     <= w_head.a;
                        r_b     <= w_head.b;
                        r_op    <= w_head.op;
                        r_cnt   <= SETTLE_LOAD;
                        r_state <= ST_DRIVE;
                    end
                end

                ST_DRIVE: begin
                    // Sample on the last settle cycle: the ALU has seen the
                    // operands for SETTLE_CYCLES edges by then.
                    if (r_cnt == 3'd1) begin
                        r_res_data  <= bus.alu_out;
                        r_res_op    <= r_op;
                        r_res_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (w_res_fire) begin
                        r_res_valid <= 1'b0;
                        if (w_pop) begin
                            r_a     <= w_head.a;
                            r_b     <= w_head.b;
                            r_op    <= w_head.op;
                            r_cnt   <= SETTLE_LOAD;
                            r_state <= ST_DRIVE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // req_ready depends only on registered occupancy, never on this cycle's pop.
    assign bus.req_ready = !w_full;
    assign bus.alu_a     = r_a;
    assign bus.alu_b     = r_b;
    assign bus.alu_ctrl  = r_op;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_op    = r_res_op;
    assign bus.busy      = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, number of cycles the ALU inputs are held stable before the result is sampled (legal range 1..7).
REQ-002 Parameter FIFO_DEPTH, default 2, number of request entries buffered ahead of the ALU (fixed at 2 in this revision).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  upstream request present.
REQ-006 req_ready  output  1  request buffer can accept this cycle.
REQ-007 req_a  input  4  operand A.
REQ-008 req_b  input  4  operand B.
REQ-009 req_op  input  3  ALU control code, passed through opaquely.
REQ-010 alu_a  output  4  operand A driven to the combinational ALU.
REQ-011 alu_b  output  4  operand B driven to the ALU.
REQ-012 alu_ctrl  output  3  control code driven to the ALU.
REQ-013 alu_out  input  4  combinational ALU result.
REQ-014 res_valid  output  1  result available.
REQ-015 res_ready  input  1  downstream accepts result.
REQ-016 res_data  output  4  captured ALU result.
REQ-017 res_op  output  3  op code that produced res_data.
REQ-018 busy  output  1  high whenever state is not IDLE or the buffer is non-empty.

Function
REQ-019 Request accepted on any rising edge where req_valid and req_ready are both high; the {a,b,op} triple is pushed into a 2-entry in-order FIFO.
REQ-020 req_ready SHALL equal not-full; no combinational pass-through from pop to req_ready.
REQ-021 FSM states: IDLE, DRIVE, HOLD.
REQ-022 IDLE: if FIFO non-empty, pop head into operand registers, load settle counter with SETTLE_CYCLES, go to DRIVE; else remain.
REQ-023 DRIVE: alu_a/alu_b/alu_ctrl equal the operand registers; counter decrements each cycle; on the edge where counter is 1, alu_out is registered into res_data, operand op into res_op, res_valid set, go to HOLD.
REQ-024 HOLD: res_valid, res_data, res_op held stable until res_valid&&res_ready; on that edge res_valid clears and, if FIFO non-empty, next entry is popped and state goes directly to DRIVE, else to IDLE.
REQ-025 Latency with empty FIFO, SETTLE_CYCLES=1: request accepted at edge N, res_valid high after edge N+2; back-to-back throughput one result per SETTLE_CYCLES+1 cycles with res_ready held high.
REQ-026 Simultaneous push and pop in one cycle SHALL be legal; FIFO occupancy unchanged, order preserved.
REQ-027 alu_a/alu_b/alu_ctrl hold their last driven values in IDLE and HOLD; they change only on a pop.
REQ-028 FIFO pointers wrap modulo 2; push when full and pop when empty SHALL never occur by construction.

Reset
REQ-029 On rst_n low, immediately: state IDLE, FIFO empty, req_ready 1, res_valid 0, res_data 0, res_op 0, alu_a 0, alu_b 0, alu_ctrl 0, busy 0, counter 0.
REQ-030 Reset mid-operation SHALL discard the in-flight operation and all buffered requests; no result is emitted for them after release.
REQ-031 First request may be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package alu_pkg SHALL hold DATA_W=4, OP_W=3, and the FSM state enum.
REQ-033 FIFO SHALL be a separate sub-module alu_req_fifo (push/pop/full/empty, 2 entries, async active-low reset).
REQ-034 The ALU itself is not instantiated; alu_issue_ctrl connects to it at the top level.

Verification
REQ-035 Single op: push a=4'b1100, b=4'b0001, op=3'b000, ALU model returns 4'b0100 -> res_valid two cycles after accept, res_data=4'b0100, res_op=3'b000.
REQ-036 Back-to-back: three requests on consecutive cycles, res_ready high -> results in order, 2 cycles apart, req_ready low exactly while FIFO full.
REQ-037 Backpressure: res_ready low 6 cycles with 4 requests offered -> one result held stable, 2 buffered, req_ready low, fourth request stalls; release -> all emitted in order.
REQ-038 SETTLE_CYCLES=3: alu_out changes on cycle 1 and 2 of DRIVE -> res_data equals value present on 3rd cycle; latency 4 cycles.
REQ-039 Reset in DRIVE with one entry buffered -> all outputs at reset values immediately; no result emitted after release until a new request.
